// File: rtl/xg_lsu.sv
// Load/store unit: turns the datapath's load/store into a req/ack data-memory
// access, stalling the core until the access completes or is rejected.
module xg_lsu #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memread,
    input  logic                 memwrite,
    input  logic [2:0]           funct3,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [XLEN-1:0]      wdata,
    output logic                 stall,
    output logic                 done,
    output logic [XLEN-1:0]      rdata,
    output logic                 misalign,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic [XLEN-1:0]      dmem_rdata,
    input  logic                 dmem_ack,
    output logic [1:0]           state_dbg
);

    // Memory handshake: dmem_req rises the cycle after an access is accepted
    // and stays high, with every dmem_* output frozen, until the cycle in
    // which dmem_ack=1 is sampled; req drops on the following edge.

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [3:0]             be_q, be_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic [XLEN-1:0]        rdata_q, rdata_d;
    logic                   done_q, done_d;
    logic                   mis_q, mis_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [1:0]             off_q, off_d;

    logic                   access;
    logic                   illegal;
    logic [3:0]             be_c;
    logic [XLEN-1:0]        st_c;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [XLEN-1:0]        ld_ext;

    assign access  = memread | memwrite;
    assign illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)
                   || ((funct3[1:0] == 2'b01) && addr[0])
                   || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        be_c = 4'b1111;
        st_c = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr[1:0];
                st_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c = 4'b0011 << {addr[1], 1'b0};
                st_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the offset and size captured at request time, not the live inputs.
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (off_q)
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            2'd3:    ld_byte = dmem_rdata[31:24];
            default: ;
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{(XLEN-8){~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{(XLEN-16){~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        mis_d   = mis_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        we_d    = memwrite;
                        addr_d  = {addr[ADDR_SIZE-1:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = st_c;
                        size_d  = funct3[1:0];
                        uns_d   = funct3[2];
                        off_d   = addr[1:0];
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = we_q ? '0 : ld_ext;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                mis_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    assign stall      = access & (state_q != DONE);
    assign done       = done_q;
    assign misalign   = mis_q;
    assign rdata      = rdata_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_xg_lsu.sv
// Randomized bench for xg_lsu: a behavioural model derives lane enables, store
// data, extended load data and stall counts for each access.
module tb_xg_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [1:0]  state_dbg;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  xg_lsu #(.XLEN(32), .ADDR_SIZE(32)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .misalign(misalign), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit legal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
    return (a % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int nb = nbytes(f3);
    int first = (a % 4) / nb * nb;
    return 4'(((1 << nb) - 1) << first);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r = '0;
    int nb = nbytes(f3);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int nb = nbytes(f3);
    int shift = ((a % 4) / nb * nb) * 8;
    longint mask = (64'd1 << (nb * 8)) - 1;
    longint v = (longint'(word) >> shift) & mask;
    if (!f3[2] && nb < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    return 32'(v);
  endfunction

  // driver: one instruction held until done, memory acks after 'waits' extra cycles
  task automatic run_acc(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mem_word, input int waits, input string tag);
    bit          ok = legal(f3, a);
    bit          seen_done = 1'b0;
    int          stall_cnt = 0, req_cyc = 0, req_rise = 0;
    logic        prev_req;
    logic [31:0] exp_rd, got_exp;
    exp_rd = (!ok || wr) ? 32'h0 : model_load(f3, a, mem_word);
    exp_q.push_back(exp_rd);
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd; dmem_ack = 1'b0;
    prev_req = dmem_req;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (dmem_req && !prev_req) req_rise++;
      prev_req = dmem_req;
      if (done) begin seen_done = 1'b1; break; end
      if (stall) stall_cnt++;
      dmem_ack = 1'b0;
      if (dmem_req) begin
        req_cyc++;
        check({tag, " dmem_addr"}, dmem_addr, {a[31:2], 2'b00});
        check({tag, " dmem_be"}, {28'h0, dmem_be}, {28'h0, model_be(f3, a)});
        check({tag, " dmem_we"}, {31'h0, dmem_we}, {31'h0, wr});
        if (wr) check({tag, " dmem_wdata"}, dmem_wdata, model_wdata(f3, wd));
        if (req_cyc == waits + 1) begin
          dmem_ack = 1'b1;
          dmem_rdata = mem_word;
        end
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    check({tag, " done seen"}, {31'h0, seen_done}, 32'h1);
    got_exp = exp_q.pop_front();
    if (seen_done) begin
      check({tag, " rdata"}, rdata, got_exp);
      check({tag, " misalign"}, {31'h0, misalign}, {31'h0, !ok});
      check({tag, " stall in done"}, {31'h0, stall}, 32'h0);
      check({tag, " stall cycles"}, stall_cnt, ok ? waits + 2 : 1);
      check({tag, " requests"}, req_rise, ok ? 1 : 0);
    end
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk); #1;
    check({tag, " done cleared"}, {31'h0, done}, 32'h0);
    check({tag, " back to idle"}, {30'h0, state_dbg}, 32'h0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        rd, wr;
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; funct3 = 3'b0;
    addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset req", {31'h0, dmem_req}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset misalign", {31'h0, misalign}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset dmem_addr", dmem_addr, 32'h0);
    check("reset dmem_be", {28'h0, dmem_be}, 32'h0);
    check("reset dmem_wdata", dmem_wdata, 32'h0);
    check("reset state", {30'h0, state_dbg}, 32'h0);
    reset = 1'b0;

    // non-memory instructions
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("nomem stall", {31'h0, stall}, 32'h0);
      check("nomem req", {31'h0, dmem_req}, 32'h0);
    end

    run_acc(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0, "lb");
    run_acc(1, 0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_1234, 3, "lhu");
    run_acc(0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'hDEAD_0000, 2, "sh");
    run_acc(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_1111, 0, "lw mis");
    run_acc(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h1111_1111, 0, "f3 011");
    run_acc(0, 1, 3'b000, 32'h0000_0010, 32'h0000_00A5, 32'h0, 0, "sb");
    run_acc(1, 0, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_00A5, 0, "lb echo");
    run_acc(1, 1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 32'h5555_AAAA, 1, "rd+wr");

    // reset during the second busy cycle, late ack afterwards
    memwrite = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = $urandom;
    #1;
    @(negedge clk); #1;
    check("rst busy req", {31'h0, dmem_req}, 32'h1);
    @(negedge clk); #1;
    reset = 1'b1; memwrite = 1'b0;
    @(negedge clk); #1;
    check("rst state", {30'h0, state_dbg}, 32'h0);
    check("rst req", {31'h0, dmem_req}, 32'h0);
    check("rst done", {31'h0, done}, 32'h0);
    check("rst misalign", {31'h0, misalign}, 32'h0);
    reset = 1'b0; dmem_ack = 1'b1;
    @(negedge clk); #1;
    check("late ack done", {31'h0, done}, 32'h0);
    check("late ack req", {31'h0, dmem_req}, 32'h0);
    dmem_ack = 1'b0;
    @(negedge clk); #1;
    check("late ack done2", {31'h0, done}, 32'h0);
    check("late ack state", {30'h0, state_dbg}, 32'h0);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = {20'h0, 12'($urandom_range(0, 4095))};
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      run_acc(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 4), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
